// File: rtl/vga_pmod_out.sv
// Purpose : final video output stage; realigns timing to compositor latency, blanks, applies sync polarity, packs PMOD byte, counts frames, raises vblank irq.
// Latency : colour 1 cycle after r/g/b_in; syncs and visible DELAY+1 cycles after the timing inputs.
// Backpres: none; streaming pixel pipeline that advances every clk, no stall path.
//
// Ports:
//   clk, reset                   pixel clock, synchronous active-high reset
//   hsync_in, vsync_in           raw syncs from the video controller (active-high pulse)
//   visible_in                   active-area flag from the video controller
//   r_in, g_in, b_in             2-bit composited colour, DELAY cycles behind timing
//   sync_pol                     0 = negative output syncs, 1 = positive
//   irq_clear                    one-cycle strobe clearing irq_pending
//   test_mode                    colour-bar select (only when VGA_TEST_PATTERN_EN is defined)
//   uo_out                       PMOD byte {HS,B0,G0,R0,VS,B1,G1,R1}
//   frame_count                  completed frames since reset (wraps)
//   irq_pending                  sticky vblank interrupt
//
// Build option: define VGA_TEST_PATTERN_EN to add the test_mode input and colour-bar generator.
module vga_pmod_out #(
    parameter int DELAY = 2           // compositor latency, legal range 0..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        visible_in,
    input  logic [1:0]  r_in,
    input  logic [1:0]  g_in,
    input  logic [1:0]  b_in,
    input  logic        sync_pol,
    input  logic        irq_clear,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [7:0]  uo_out,
    output logic [15:0] frame_count,
    output logic        irq_pending
);

    // Timing signals aligned with the colour arriving from the compositor.
    logic hs_d;
    logic vs_d;
    logic vis_d;

    generate
        if (DELAY == 0) begin : g_no_dly
            assign hs_d  = hsync_in;
            assign vs_d  = vsync_in;
            assign vis_d = visible_in;
        end else begin : g_dly
            // Each stage carries {hsync, vsync, visible}.
            logic [DELAY-1:0][2:0] tim_pipe_q;
            logic [DELAY-1:0][2:0] tim_pipe_d;

            always_comb begin
                tim_pipe_d    = tim_pipe_q;
                tim_pipe_d[0] = {hsync_in, vsync_in, visible_in};
                for (int i = 1; i < DELAY; i++) begin
                    tim_pipe_d[i] = tim_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    tim_pipe_q <= '0;
                end else begin
                    tim_pipe_q <= tim_pipe_d;
                end
            end

            assign {hs_d, vs_d, vis_d} = tim_pipe_q[DELAY-1];
        end
    endgenerate

    logic [7:0]  uo_q,          uo_d;
    logic        vs_prev_q,     vs_prev_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        irq_q,         irq_d;
    logic [1:0]  r_src, g_src, b_src;
    logic [1:0]  r_px,  g_px,  b_px;
    logic        hs_o, vs_o;
    logic        vs_rise;

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0]  col_q, col_d;
    logic [2:0]  bar_idx;
`endif

    always_comb begin
        r_src = r_in;
        g_src = g_in;
        b_src = b_in;
`ifdef VGA_TEST_PATTERN_EN
        // Eight 64-pixel-wide bars; hsync resets the column so every line starts at bar 0.
        bar_idx = col_q[8:6];
        col_d   = col_q;
        if (hs_d) begin
            col_d = '0;
        end else if (vis_d) begin
            col_d = col_q + 10'd1;
        end
        if (test_mode) begin
            r_src = {2{bar_idx[2]}};
            g_src = {2{bar_idx[1]}};
            b_src = {2{bar_idx[0]}};
        end
`endif
        // Blank colour outside the active area.
        r_px = vis_d ? r_src : 2'b00;
        g_px = vis_d ? g_src : 2'b00;
        b_px = vis_d ? b_src : 2'b00;

        hs_o = sync_pol ? hs_d : ~hs_d;
        vs_o = sync_pol ? vs_d : ~vs_d;

        uo_d = {hs_o, b_px[0], g_px[0], r_px[0], vs_o, b_px[1], g_px[1], r_px[1]};

        // Frame boundary = rising edge of the aligned vsync.
        vs_rise       = vs_d & ~vs_prev_q;
        vs_prev_d     = vs_d;
        frame_count_d = frame_count_q + {15'd0, vs_rise};
        // A new vblank takes priority over a simultaneous clear.
        irq_d         = vs_rise | (irq_q & ~irq_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uo_q          <= sync_pol ? 8'h00 : 8'h88;
            vs_prev_q     <= 1'b0;
            frame_count_q <= '0;
            irq_q         <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            col_q         <= '0;
`endif
        end else begin
            uo_q          <= uo_d;
            vs_prev_q     <= vs_prev_d;
            frame_count_q <= frame_count_d;
            irq_q         <= irq_d;
`ifdef VGA_TEST_PATTERN_EN
            col_q         <= col_d;
`endif
        end
    end

    assign uo_out      = uo_q;
    assign frame_count = frame_count_q;
    assign irq_pending = irq_q;

endmodule

// File: tb/tb_vga_pmod_out.sv
// Purpose : directed self-checking bench for vga_pmod_out with DELAY=2.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpres: none.
module tb_vga_pmod_out;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in, visible_in;
    logic [1:0]  r_in, g_in, b_in;
    logic        sync_pol, irq_clear;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode;
`endif
    logic [7:0]  uo_out;
    logic [15:0] frame_count;
    logic        irq_pending;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_pmod_out #(.DELAY(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .visible_in  (visible_in),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .sync_pol    (sync_pol),
        .irq_clear   (irq_clear),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .uo_out      (uo_out),
        .frame_count (frame_count),
        .irq_pending (irq_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle vsync pulse followed by enough idle cycles for the count to land.
    task automatic vs_pulse();
        vsync_in = 1'b1;
        step(1);
        vsync_in = 1'b0;
        step(4);
    endtask

    initial begin
        reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; visible_in = 1'b0;
        r_in = 2'b00; g_in = 2'b00; b_in = 2'b00;
        sync_pol = 1'b0; irq_clear = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        step(3);
        chk("rst_uo_in_reset", uo_out, 8'h88);
        reset = 1'b0;
        step(5);
        chk("rst_uo", uo_out, 8'h88);
        chk("rst_fc", frame_count, 0);
        chk("rst_irq", irq_pending, 0);

        // Positive syncs, full-white visible pixels.
        sync_pol = 1'b1;
        visible_in = 1'b1; r_in = 2'b11; g_in = 2'b11; b_in = 2'b11;
        step(3);
        chk("white", uo_out, 8'h77);

        // hsync pulse appears on HS exactly DELAY+1 cycles later, for one cycle.
        hsync_in = 1'b1;
        step(1);
        hsync_in = 1'b0;
        step(1);
        chk("hs_early", uo_out[7], 0);
        step(1);
        chk("hs_on", uo_out, 8'hF7);
        step(1);
        chk("hs_off", uo_out[7], 0);

        // Colour has a one-cycle latency and the bit packing is R0@4, G1@1.
        r_in = 2'b01; g_in = 2'b10; b_in = 2'b00;
        step(1);
        chk("pack", uo_out, 8'h12);

        // Blanking follows visible with DELAY+1 latency.
        r_in = 2'b11; g_in = 2'b11; b_in = 2'b11;
        visible_in = 1'b0;
        step(2);
        chk("blank_late", uo_out, 8'h77);
        step(1);
        chk("blank", uo_out, 8'h00);
        visible_in = 1'b1;
        step(2);
        chk("unblank_early", uo_out, 8'h00);
        step(1);
        chk("unblank", uo_out, 8'h77);

        // Negative polarity: idle syncs drive high.
        sync_pol = 1'b0;
        step(1);
        chk("neg_pol", uo_out, 8'hFF);
        sync_pol = 1'b1;

        // First vsync: VS output timing, then frame count.
        vsync_in = 1'b1;
        step(1);
        vsync_in = 1'b0;
        step(2);
        chk("vs_on", uo_out[3], 1);
        step(2);
        chk("fc1", frame_count, 1);
        vs_pulse();
        vs_pulse();
        chk("fc3", frame_count, 3);
        chk("irq_set", irq_pending, 1);

        irq_clear = 1'b1;
        step(1);
        irq_clear = 1'b0;
        chk("irq_clr", irq_pending, 0);
        chk("fc3_hold", frame_count, 3);

        // Clear coincides with the edge-detect cycle: set wins.
        vsync_in = 1'b1;
        step(1);
        vsync_in = 1'b0;
        step(1);
        irq_clear = 1'b1;
        step(1);
        irq_clear = 1'b0;
        step(2);
        chk("irq_set_wins", irq_pending, 1);
        chk("fc4", frame_count, 4);

        // Wrap via preload.
        force dut.frame_count_q = 16'hFFFE;
        step(2);
        release dut.frame_count_q;
        step(1);
        chk("fc_preload", frame_count, 16'hFFFE);
        vs_pulse();
        chk("fc_ffff", frame_count, 16'hFFFF);
        vs_pulse();
        chk("fc_wrap", frame_count, 16'h0000);
        chk("irq_wrap", irq_pending, 1);

        // Reset mid-vsync flushes the pipe; release itself is not an edge.
        vsync_in = 1'b1;
        step(1);
        reset = 1'b1;
        step(2);
        vsync_in = 1'b0;
        reset = 1'b0;
        step(4);
        chk("mid_rst_fc", frame_count, 0);
        chk("mid_rst_irq", irq_pending, 0);
        vs_pulse();
        chk("mid_rst_fc1", frame_count, 1);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars across one visible line; r/g/b inputs are zero so only bars show.
        r_in = 2'b00; g_in = 2'b00; b_in = 2'b00;
        visible_in = 1'b0;
        test_mode = 1'b1;
        step(3);
        hsync_in = 1'b1;
        step(1);
        hsync_in = 1'b0;
        visible_in = 1'b1;
        step(3);
        for (int k = 0; k < 512; k++) begin
            case (k)
                0, 63:    chk("bar0", uo_out & 8'h77, 8'h00);
                64, 127:  chk("bar1", uo_out & 8'h77, 8'h44);
                256:      chk("bar4", uo_out & 8'h77, 8'h11);
                448, 511: chk("bar7", uo_out & 8'h77, 8'h77);
                default:  ;
            endcase
            step(1);
        end
        test_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
